// File: rtl/frost_lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and
// the controller state enum.
package frost_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: little-endian byte/half
// extraction with sign or zero extension for loads, and read-modify-write
// lane merge for sub-word stores. Size 3 behaves as a word access; a half
// access looks only at lane bit 1.
module lsu_align
    import frost_lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

    // Load path: select the addressed lane and extend it to 32 bits.
    always_comb begin
        o_load_data = i_word;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // Store path: overwrite only the addressed lane of the current RAM word.
    always_comb begin
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: o_merged[{i_lane, 3'b000} +: 8]      = i_wdata[7:0];
            SZ_HALF: o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-addressed RAM
// without byte enables. Sub-word stores are done as read-modify-write.
// Build option LSU_MISALIGN_CHECK_EN: misaligned half/word accesses and
// size 3 are rejected with rsp_err at N+1 without touching memory.
//
// state | meaning
// IDLE  | ready for a request, captures fields on accept
// ISSUE | mem_re for loads / sub-word stores, mem_we for word stores
// WAIT  | RAM data valid; register load result or merged store word
// WRITE | mem_we with the merged word
// RESP  | one-cycle rsp_valid
module load_store_unit
    import frost_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_din,
    output logic        o_mem_re,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_dout
);

    lsu_state_t  r_state;
    lsu_state_t  w_next;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_word_acc;
    logic        w_skip_mem;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

`ifdef LSU_MISALIGN_CHECK_EN
    logic        r_err;
    logic        w_misalign;

    assign w_misalign = ((i_req_size == SZ_HALF) &&  i_req_addr[0])
                      || ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00))
                      ||  (i_req_size == SZ_RSVD);
    assign w_skip_mem = w_misalign;
    assign o_rsp_err  = (r_state == RESP) && r_err;
`else
    assign w_skip_mem = 1'b0;
    assign o_rsp_err  = 1'b0;
`endif

    assign w_accept    = i_req_valid && (r_state == IDLE);
    assign w_word_acc  = (r_size == SZ_WORD) || (r_size == SZ_RSVD);
    assign o_mem_addr  = r_addr[31:2];
    assign o_mem_din   = (r_state == WRITE) ? r_merged : r_wdata;
    assign o_rsp_rdata = r_rdata;

    lsu_align u_align (
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_lane      (r_addr[1:0]),
        .i_word      (i_mem_dout),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    // State register; reset forces IDLE so the RAM strobes drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode, strobes depend only on registered state.
    always_comb begin
        w_next      = r_state;
        o_req_ready = 1'b0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_next = w_skip_mem ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (r_we && w_word_acc) begin
                    o_mem_we = 1'b1;
                    w_next   = RESP;
                end else begin
                    o_mem_re = 1'b1;
                    w_next   = WAIT;
                end
            end
            WAIT: begin
                w_next = r_we ? WRITE : RESP;
            end
            WRITE: begin
                o_mem_we = 1'b1;
                w_next   = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture, merge/load result registers; rdata is cleared as a
    // store or error response is entered and otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_merged   <= '0;
            r_rdata    <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_err      <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_we       <= i_req_we;
                r_size     <= i_req_size;
                r_unsigned <= i_req_unsigned;
                r_addr     <= i_req_addr;
                r_wdata    <= i_req_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
                r_err      <= w_misalign;
                if (w_misalign) begin
                    r_rdata <= '0;
                end
`endif
            end
            if ((r_state == ISSUE) && r_we && w_word_acc) begin
                r_rdata <= '0;
            end
            if (r_state == WAIT) begin
                if (r_we) begin
                    r_merged <= w_merged;
                end else begin
                    r_rdata  <= w_load_data;
                end
            end
            if (r_state == WRITE) begin
                r_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency RAM model.
// Expected values are hand-computed from the RAM image the sequence builds.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [29:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_dout;

    logic [31:0] ram [0:63];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int re_cnt = 0, we_cnt = 0, rsp_cnt = 0, both_cnt = 0;
    int re_cyc = 0, we_cyc = 0, rsp_cyc = 0;
    logic [29:0] we_addr_s = '0;
    logic [31:0] we_din_s  = '0;
    logic [31:0] rdata_s   = '0;
    logic        err_s     = 1'b0;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
        .o_mem_addr     (mem_addr),
        .o_mem_din      (mem_din),
        .o_mem_re       (mem_re),
        .o_mem_we       (mem_we),
        .i_mem_dout     (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[5:0]] <= mem_din;
        if (mem_re) mem_dout <= ram[mem_addr[5:0]];
    end

    always @(negedge clk) begin
        if (mem_re) begin re_cnt++; re_cyc = cyc; end
        if (mem_we) begin we_cnt++; we_cyc = cyc; we_addr_s = mem_addr; we_din_s = mem_din; end
        if (mem_re && mem_we) both_cnt++;
        if (rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; rdata_s = rsp_rdata; err_s = rsp_err; end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic xact(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_re, input int exp_re_off,
                        input int exp_we, input int exp_we_off,
                        input logic [29:0] exp_we_addr, input logic [31:0] exp_din);
        int t0, re0, we0, rsp0, k;
        step();
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        t0 = cyc; re0 = re_cnt; we0 = we_cnt; rsp0 = rsp_cnt;
        step();
        req_valid = 1'b0;
        k = 0;
        while ((rsp_cnt == rsp0) && (k < 10)) begin
            step();
            k++;
        end
        step(); step(); step();
        chk({tag, ".rsp_count"}, 32'(rsp_cnt - rsp0), 32'd1);
        chk({tag, ".latency"}, 32'(rsp_cyc - t0), 32'(exp_lat));
        chk({tag, ".rdata"}, rdata_s, exp_rdata);
        chk({tag, ".err"}, {31'd0, err_s}, {31'd0, exp_err});
        chk({tag, ".re_count"}, 32'(re_cnt - re0), 32'(exp_re));
        chk({tag, ".we_count"}, 32'(we_cnt - we0), 32'(exp_we));
        if (exp_re != 0) chk({tag, ".re_cycle"}, 32'(re_cyc - t0), 32'(exp_re_off));
        if (exp_we != 0) begin
            chk({tag, ".we_cycle"}, 32'(we_cyc - t0), 32'(exp_we_off));
            chk({tag, ".we_addr"}, {2'b00, we_addr_s}, {2'b00, exp_we_addr});
            chk({tag, ".we_din"}, we_din_s, exp_din);
        end
    endtask

    initial begin
        int we0, rsp0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[4]       = 32'h8899AABB;
        mem_dout     = '0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        step(); step();
        chk("reset.req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset.mem_re",    {31'd0, mem_re},    32'd0);
        chk("reset.mem_we",    {31'd0, mem_we},    32'd0);
        chk("reset.rdata",     rsp_rdata,          32'd0);
        chk("reset.err",       {31'd0, rsp_err},   32'd0);
        chk("reset.mem_addr",  {2'b00, mem_addr},  32'd0);
        chk("reset.mem_din",   mem_din,            32'd0);
        rst_n = 1'b1;
        step();
        chk("release.req_ready", {31'd0, req_ready}, 32'd1);

        //   tag     we    size  uns   addr          wdata         lat rdata          err  re off we off addr  din
        xact("lb13",  1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        3, 32'hFFFFFF88, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
        xact("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        3, 32'h00000088, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
        xact("lh10",  1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        3, 32'hFFFFAABB, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
        xact("lhu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        3, 32'h00008899, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
        xact("sb11",  1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF5C, 4, 32'h00000000, 1'b0, 1, 1, 1, 3, 30'd4, 32'h88995CBB);
        xact("lw10",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        3, 32'h88995CBB, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
        xact("sw20",  1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 2, 32'h00000000, 1'b0, 0, 0, 1, 1, 30'd8, 32'hDEADBEEF);
        xact("lw20",  1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        3, 32'hDEADBEEF, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
        xact("sh22",  1'b1, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 4, 32'h00000000, 1'b0, 1, 1, 1, 3, 30'd8, 32'hABCDBEEF);
        xact("lbu21", 1'b0, 2'd0, 1'b1, 32'h21, 32'h0,        3, 32'h000000BE, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
        step(); step();
        chk("rdata_hold", rsp_rdata, 32'h000000BE);

`ifdef LSU_MISALIGN_CHECK_EN
        xact("lh11",  1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 0, 0, 30'd0, 32'h0);
        xact("lsz3",  1'b0, 2'd3, 1'b0, 32'h20, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 0, 0, 30'd0, 32'h0);
        xact("lw23",  1'b0, 2'd2, 1'b0, 32'h23, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 0, 0, 30'd0, 32'h0);
`else
        xact("lh11",  1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        3, 32'h00005CBB, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
        xact("lsz3",  1'b0, 2'd3, 1'b0, 32'h20, 32'h0,        3, 32'hABCDBEEF, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
        xact("lw23",  1'b0, 2'd2, 1'b0, 32'h23, 32'h0,        3, 32'hABCDBEEF, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
`endif

        // Reset during WAIT of a byte store must abort it cleanly.
        step();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h00000077;
        we0 = we_cnt; rsp0 = rsp_cnt;
        step();
        req_valid = 1'b0;
        chk("abort.issue_re", {31'd0, mem_re}, 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("abort.mem_re",    {31'd0, mem_re},    32'd0);
        chk("abort.mem_we",    {31'd0, mem_we},    32'd0);
        chk("abort.req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort.mem_addr",  {2'b00, mem_addr},  32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("abort.ready_after", {31'd0, req_ready}, 32'd1);
        step(); step(); step(); step();
        chk("abort.no_we",   32'(we_cnt - we0),   32'd0);
        chk("abort.no_rsp",  32'(rsp_cnt - rsp0), 32'd0);
        chk("abort.ram4",    ram[4],              32'h88995CBB);

        xact("lb11",  1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        3, 32'h0000005C, 1'b0, 1, 1, 0, 0, 30'd0, 32'h0);
        chk("re_we_overlap", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one parameter per line: none; all widths are fixed (32-bit data, 30-bit word address).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU access request.
REQ-005 req_ready  output  1  high only in IDLE; request is accepted when req_valid & req_ready.
REQ-006 req_we / req_size[1:0] / req_unsigned  input  1/2/1  store flag; size 0=byte, 1=half, 2=word, 3=reserved; zero-extend loads.
REQ-007 req_addr[31:0] / req_wdata[31:0]  input  32/32  byte address; store data in the low bits.
REQ-008 rsp_valid / rsp_rdata[31:0] / rsp_err  output  1/32/1  one-cycle completion pulse, load data, misalignment error.
REQ-009 mem_addr[29:0] / mem_din[31:0] / mem_re / mem_we  output  word-address RAM port; the RAM has no byte enables.
REQ-010 mem_dout[31:0]  input  32  RAM read data; valid the cycle after mem_re is high.

Function
REQ-011 SHALL implement the states IDLE, ISSUE, WAIT, WRITE and RESP.
REQ-012 On accept (cycle N) SHALL capture all req_* fields and go to ISSUE; mem_addr SHALL be req_addr[31:2].
REQ-013 ISSUE, load or sub-word store: SHALL drive mem_re=1 for one cycle, then go to WAIT.
REQ-014 ISSUE, word store: SHALL drive mem_we=1 with mem_din=wdata for one cycle, then go to RESP.
REQ-015 WAIT, load: SHALL extract the byte or half selected by addr[1:0] (little-endian), sign- or zero-extend it, register it into rsp_rdata, then go to RESP.
REQ-016 WAIT, sub-word store: SHALL merge wdata[7:0] or wdata[15:0] into mem_dout at the selected lane, register the result, then go to WRITE.
REQ-017 WRITE: SHALL drive mem_we=1 with the merged word for one cycle, then go to RESP.
REQ-018 RESP: SHALL drive rsp_valid=1 for exactly one cycle, then go to IDLE; there is no response backpressure.
REQ-019 Latency (accept at N): load responds at N+3, word store at N+2, sub-word store at N+4, error at N+1.
REQ-020 mem_re and mem_we SHALL never be high in the same cycle and SHALL be decoded from the state register only.
REQ-021 rsp_rdata SHALL hold its last value until the next load response; it SHALL be 0 for stores.
REQ-022 req_valid outside IDLE SHALL be ignored.
REQ-023 mem_addr and mem_din SHALL be stable for every cycle in which mem_re or mem_we is high.

Reset
REQ-024 While rst_n=0, every output SHALL be 0 except req_ready; the state SHALL be IDLE; captured fields SHALL be cleared.
REQ-025 req_ready SHALL be 1 in the first cycle after reset release.
REQ-026 Reset asserted mid-operation SHALL drop mem_re and mem_we immediately, SHALL leave no partial or late write, and SHALL produce no rsp_valid for the aborted access.

Configuration
REQ-027 Macro LSU_MISALIGN_CHECK_EN defined: the following SHALL skip memory access, go IDLE->RESP and respond with rsp_err=1 and rsp_rdata=0 at N+1:
  - a half access with addr[0]=1;
  - a word access with addr[1:0]!=0;
  - size 3.
REQ-028 LSU_MISALIGN_CHECK_EN undefined: rsp_err SHALL be constant 0.
  - A half access SHALL ignore addr[0].
  - A word access SHALL ignore addr[1:0].
  - Size 3 SHALL be treated as a word access.

Structure
REQ-029 A shared package frost_lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-030 A combinational sub-module lsu_align SHALL hold the lane extract and extension logic plus the store merge logic; the FSM SHALL stay in load_store_unit.

Verification
REQ-031 RAM word 4 = 0x8899AABB; signed byte load at 0x13 -> rsp_rdata=0xFFFFFF88 at N+3; the unsigned load -> 0x00000088.
REQ-032 Signed half load at 0x10 -> 0xFFFFAABB; unsigned half load at 0x12 -> 0x00008899; mem_re high exactly one cycle, at N+1.
REQ-033 Byte store 0x5C at 0x11 -> mem_re at N+1, mem_we at N+3 with mem_addr=4 and mem_din=0x88995CBB, rsp_valid at N+4; readback matches.
REQ-034 Word store 0xDEADBEEF at 0x20 -> mem_we at N+1 only (mem_addr=8, no mem_re), rsp_valid at N+2; word load readback = 0xDEADBEEF.
REQ-035 Half load at 0x11 with the macro defined -> rsp_err=1 at N+1, no mem_re or mem_we; without the macro -> rsp_err=0 and data from 0x10.
REQ-036 rst_n pulsed low during WAIT of a byte store -> no mem_we ever, RAM word unchanged, no rsp_valid, req_ready=1 after release.
